// File: rtl/operand_stack_pkg.sv
// wasm_stack_pkg: op and status encodings shared by the operand stack and its users.
package wasm_stack_pkg;
  typedef enum logic [2:0] {
    OP_NONE, OP_PUSH, OP_POP, OP_REPLACE, OP_BINOP, OP_DUP, OP_SWAP, OP_FLUSH
  } stack_op_t;
  typedef enum logic [1:0] {ST_NONE, ST_EMPTY, ST_UNDERFLOW, ST_OVERFLOW} stack_status_t;
endpackage

// File: rtl/operand_stack_if.sv
// operand_stack_if: decoder/ALU-facing op, operand and peek bundle of the operand stack.
interface operand_stack_if #(parameter int WIDTH = 32, parameter int DEPTH = 6) ();
  import wasm_stack_pkg::*;
  stack_op_t op;
  logic [WIDTH-1:0] data;
  logic [DEPTH-1:0] peek_idx;
  logic [WIDTH-1:0] tos;
  logic [WIDTH-1:0] nos;
  logic [WIDTH-1:0] peek_data;
  logic peek_valid;
  logic [DEPTH:0] count;
  logic full;
  stack_status_t status;
  modport master (output op, data, peek_idx, input tos, nos, peek_data, peek_valid, count, full, status);
  modport slave (input op, data, peek_idx, output tos, nos, peek_data, peek_valid, count, full, status);
endinterface

// File: rtl/operand_stack_ram.sv
// stack_ram: entry storage with two async read ports and two write ports (second one serves SWAP).
module stack_ram #(parameter int WIDTH = 32, parameter int DEPTH = 6) (
  input  logic clk,
  input  logic we0,
  input  logic [DEPTH-1:0] wa0,
  input  logic [WIDTH-1:0] wd0,
  input  logic we1,
  input  logic [DEPTH-1:0] wa1,
  input  logic [WIDTH-1:0] wd1,
  input  logic [DEPTH-1:0] ra_a,
  input  logic [DEPTH-1:0] ra_b,
  output logic [WIDTH-1:0] rd_a,
  output logic [WIDTH-1:0] rd_b
);
  logic [WIDTH-1:0] mem [1 << DEPTH];
  always_ff @(posedge clk) begin
    if (we0) mem[wa0] <= wd0;
    if (we1) mem[wa1] <= wd1;
  end
  assign rd_a = mem[ra_a];
  assign rd_b = mem[ra_b];
endmodule

// File: rtl/operand_stack.sv
// operand_stack: Wasm operand stack with shadow TOS/NOS registers, status reporting and a registered peek port.
module operand_stack import wasm_stack_pkg::*; #(parameter int WIDTH = 32, parameter int DEPTH = 6) (
  input logic clk,
  input logic reset,
  operand_stack_if.slave s
);
  localparam logic [DEPTH:0] MAX = (DEPTH+1)'(1) << DEPTH;
  localparam logic [DEPTH:0] C2 = (DEPTH+1)'(2);
  localparam logic [DEPTH:0] C3 = (DEPTH+1)'(3);
  localparam logic [DEPTH-1:0] A1 = DEPTH'(1);
  localparam logic [DEPTH-1:0] A2 = DEPTH'(2);
  localparam logic [DEPTH-1:0] A3 = DEPTH'(3);
  logic [DEPTH:0] cnt, cnt_n;
  logic [DEPTH-1:0] c, wa0;
  logic [WIDTH-1:0] tos, nos, tos_n, nos_n, pk_d, wd0, rd_deep, rd_pk, deep;
  logic pk_v, pv, ovf, udf, legal, we0, we1;
  stack_status_t st, st_n;
  stack_op_t op;
  assign op = s.op;
  assign c = cnt[DEPTH-1:0];
  assign ovf = (op == OP_PUSH || op == OP_DUP) && cnt == MAX;
  assign udf = ((op == OP_POP || op == OP_REPLACE || op == OP_DUP) && cnt == '0) ||
               ((op == OP_BINOP || op == OP_SWAP) && cnt < C2);
  assign legal = op != OP_NONE && !ovf && !udf;
  assign pv = {1'b0, s.peek_idx} < cnt;
  assign deep = cnt >= C3 ? rd_deep : '0;
  stack_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
    .clk(clk), .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(c - A2), .wd1(tos),
    .ra_a(c - A3), .ra_b(c - A1 - s.peek_idx), .rd_a(rd_deep), .rd_b(rd_pk)
  );
  always_comb begin
    cnt_n = cnt;
    tos_n = tos;
    nos_n = nos;
    we0 = 1'b0;
    we1 = 1'b0;
    wa0 = c;
    wd0 = s.data;
    if (legal)
      case (op)
        OP_PUSH: begin we0 = 1'b1; nos_n = tos; tos_n = s.data; cnt_n = cnt + 1'b1; end
        OP_POP: begin tos_n = nos; nos_n = deep; cnt_n = cnt - 1'b1; end
        OP_REPLACE: begin we0 = 1'b1; wa0 = c - A1; tos_n = s.data; end
        OP_BINOP: begin we0 = 1'b1; wa0 = c - A2; tos_n = s.data; nos_n = deep; cnt_n = cnt - 1'b1; end
        OP_DUP: begin we0 = 1'b1; wd0 = tos; nos_n = tos; cnt_n = cnt + 1'b1; end
        OP_SWAP: begin we0 = 1'b1; we1 = 1'b1; wa0 = c - A1; wd0 = nos; tos_n = nos; nos_n = tos; end
        OP_FLUSH: begin cnt_n = '0; tos_n = '0; nos_n = '0; end
        default: ;
      endcase
    st_n = ovf ? ST_OVERFLOW : udf ? ST_UNDERFLOW : op == OP_NONE ? st : cnt_n == '0 ? ST_EMPTY : ST_NONE;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt <= '0;
      tos <= '0;
      nos <= '0;
      st <= ST_EMPTY;
      pk_d <= '0;
      pk_v <= 1'b0;
    end else begin
      cnt <= cnt_n;
      tos <= tos_n;
      nos <= nos_n;
      st <= st_n;
      pk_v <= pv;
      pk_d <= pv ? rd_pk : '0;
    end
  assign s.tos = tos;
  assign s.nos = nos;
  assign s.count = cnt;
  assign s.full = cnt == MAX;
  assign s.status = st;
  assign s.peek_data = pk_d;
  assign s.peek_valid = pk_v;
endmodule

// File: doc/operand_stack.md
Name: operand_stack

Overview:
Parametrised operand stack for the WebAssembly execution core and successor to the basic 8-bit stack.
- Generalised width and depth; count is DEPTH+1 bits, so the stack really holds 2^DEPTH entries.
- Adds the ops a Wasm datapath needs: binop (pop 2, push 1), dup, swap, flush.
- Exposes TOS, NOS and an indexed registered peek port for local/operand access.
- Sits between the instruction decoder and the ALU.

Parameters:
WIDTH, 32, data bits per entry
DEPTH, 6, log2 of entry count (MAX = 1 << DEPTH)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
op  in  3  0 NONE / 1 PUSH / 2 POP / 3 REPLACE / 4 BINOP / 5 DUP / 6 SWAP / 7 FLUSH
data  in  WIDTH  operand for PUSH / REPLACE / BINOP
peek_idx  in  DEPTH  depth below TOS to read (0 = TOS)
tos  out  WIDTH  top of stack, registered
nos  out  WIDTH  next on stack, registered
peek_data  out  WIDTH  registered read of entry at peek_idx
peek_valid  out  1  peek_idx was < count when sampled
count  out  DEPTH+1  number of entries
full  out  1  count == MAX, combinational from count
status  out  2  0 NONE / 1 EMPTY / 2 UNDERFLOW / 3 OVERFLOW

Behaviour:
- Reset (reset low, async assert, sync deassert handled upstream):
  - count=0, tos=0, nos=0, peek_data=0, peek_valid=0, status=EMPTY.
  - Array contents are don't-care.
  - Reset asserted mid-operation aborts that op. No partial update is visible.
- Every op completes in one cycle. tos, nos, count and status reflect the new state on the cycle after the edge.
- Storage: array[0..MAX-1]; entry count-1 is TOS.
- Invariants:
  - tos = array[count-1] if count>=1, else 0.
  - nos = array[count-2] if count>=2, else 0.
  - Implement tos/nos as shadow registers, not array reads.
- Legal ops (n = count before the edge):
  - PUSH: needs n<MAX. array[n]<=data; nos<=tos; tos<=data; count n+1.
  - POP: needs n>=1. count n-1; tos<=old nos; nos<=array[n-3] (0 if n<3).
  - REPLACE: needs n>=1. array[n-1]<=data; tos<=data; count unchanged.
  - BINOP: needs n>=2. array[n-2]<=data; tos<=data; nos<=array[n-3] (0 if n<3); count n-1.
  - DUP: needs 1<=n<MAX. array[n]<=tos; nos<=tos; count n+1.
  - SWAP: needs n>=2. Exchange array[n-1] and array[n-2]; exchange tos and nos.
  - FLUSH: always legal. count=0; tos=nos=0.
  - NONE: no state change. status holds.
- Status after any legal op other than NONE: EMPTY if the new count==0, else NONE.
- Error cases. The op is ignored entirely (array, count, tos, nos unchanged) and status is set:
  - PUSH or DUP with n==MAX -> OVERFLOW.
  - DUP with n==0 -> UNDERFLOW.
  - POP or REPLACE with n==0 -> UNDERFLOW.
  - BINOP or SWAP with n<2 -> UNDERFLOW.
- Error status persists until the next non-NONE op or reset.
- Peek:
  - Every cycle, peek_data<=array[n-1-peek_idx] using the pre-op state; peek_valid<=(peek_idx<n).
  - When invalid, peek_data<=0.
  - Latency is 1 cycle. A peek and a write to the same slot in one cycle returns the old value.
- count wraps never: legal ops keep it within 0..MAX. full asserts at exactly MAX.
- No x-propagation onto outputs after reset.

Decomposition:
- Package wasm_stack_pkg holds:
  - op encodings: OP_NONE..OP_FLUSH
  - status encodings: ST_NONE, ST_EMPTY, ST_UNDERFLOW, ST_OVERFLOW
  - typedefs stack_op_t (3-bit) and stack_status_t (2-bit)
- One sub-module, stack_ram: single-clock RAM, MAX x WIDTH.
  - Two asynchronous read ports: deep-read for nos refill and peek.
  - One write port, plus a second write port for SWAP. Alternatively, implement SWAP as array[n-1]<=old nos and array[n-2]<=old tos through a dual-write RAM.
- The top level holds count, the tos/nos shadows, status and op decode.

Test Plan:
- Reset then idle: after reset release, count=0, status=EMPTY, tos=0, nos=0, full=0; POP -> status=UNDERFLOW, count stays 0.
- Push 0x11, 0x22, 0x33 -> tos=0x33, nos=0x22, count=3. BINOP with data=0x55 -> tos=0x55, nos=0x11, count=2. POP, POP -> status=EMPTY.
- DEPTH=3: 8 PUSHes (values 1..8) -> full=1, status=NONE. 9th PUSH(9) -> status=OVERFLOW, tos=8. DUP -> OVERFLOW. POP -> tos=7, status=NONE.
- Push A, B; SWAP -> tos=A, nos=B. Peek idx0 -> A and idx1 -> B a cycle later with peek_valid=1. Peek idx2 -> peek_valid=0, peek_data=0.
- Push 5 values; assert reset during a PUSH edge -> outputs go to reset values immediately (async); after release, count=0 and status=EMPTY.
- REPLACE on empty -> UNDERFLOW with state unchanged. PUSH 7, REPLACE 9 -> tos=9, count=1. FLUSH -> count=0, status=EMPTY, tos=0.
